// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module   : control
// Brief    : Multicycle RV32I datapath sequencer (Moore FSM, fetch/decode/exec)
// Revision : 1.0 - initial release
// ============================================================================
module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic       mem_resp,
    input  logic [1:0] addr_lo,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic [1:0] pcmux_sel,
    output logic       alumux1_sel,
    output logic [2:0] alumux2_sel,
    output logic       cmpmux_sel,
    output logic       marmux_sel,
    output logic [3:0] regfilemux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable
);

    localparam logic [6:0] c_OP_IMM   = 7'h13;
    localparam logic [6:0] c_OP_REG   = 7'h33;
    localparam logic [6:0] c_OP_LUI   = 7'h37;
    localparam logic [6:0] c_OP_AUIPC = 7'h17;
    localparam logic [6:0] c_OP_BR    = 7'h63;
    localparam logic [6:0] c_OP_JAL   = 7'h6F;
    localparam logic [6:0] c_OP_JALR  = 7'h67;
    localparam logic [6:0] c_OP_LOAD  = 7'h03;
    localparam logic [6:0] c_OP_STORE = 7'h23;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SRA  = 3'd2;
    localparam logic [2:0] c_ALU_SUB  = 3'd3;
    localparam logic [2:0] c_CMP_BLT  = 3'b100;
    localparam logic [2:0] c_CMP_BLTU = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_IMM, S_REG, S_LUI, S_AUIPC,
        S_BR, S_JAL, S_JALR, S_CALC_ADDR,
        S_LD1, S_LD2, S_ST1, S_ST2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_unused_funct7;

    assign w_unused_funct7 = &{1'b0, funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH1;
        else      r_state <= w_next;
    end

    // Outputs decode from state and IR fields; reset forces the idle defaults.
    always_comb begin
        w_next          = r_state;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = 2'd0;
        alumux1_sel     = 1'b0;
        alumux2_sel     = 3'd0;
        cmpmux_sel      = 1'b0;
        marmux_sel      = 1'b0;
        regfilemux_sel  = 4'd0;
        aluop           = funct3;
        cmpop           = funct3;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;
        if (rst) begin
            case (r_state)
                S_FETCH1: begin
                    load_mar = 1'b1;
                    w_next   = S_FETCH2;
                end
                S_FETCH2: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                    if (mem_resp) w_next = S_FETCH3;
                end
                S_FETCH3: begin
                    load_ir = 1'b1;
                    w_next  = S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        c_OP_IMM:   w_next = S_IMM;
                        c_OP_REG:   w_next = S_REG;
                        c_OP_LUI:   w_next = S_LUI;
                        c_OP_AUIPC: w_next = S_AUIPC;
                        c_OP_BR:    w_next = S_BR;
                        c_OP_JAL:   w_next = S_JAL;
                        c_OP_JALR:  w_next = S_JALR;
                        c_OP_LOAD,
                        c_OP_STORE: w_next = S_CALC_ADDR;
                        default:    w_next = S_FETCH1;
                    endcase
                end
                S_IMM, S_REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    alumux2_sel  = (r_state == S_REG) ? 3'd5 : 3'd0;
                    case (funct3)
                        3'b010: begin
                            cmpop          = c_CMP_BLT;
                            cmpmux_sel     = (r_state == S_IMM);
                            regfilemux_sel = 4'd1;
                        end
                        3'b011: begin
                            cmpop          = c_CMP_BLTU;
                            cmpmux_sel     = (r_state == S_IMM);
                            regfilemux_sel = 4'd1;
                        end
                        3'b101: if (funct7[5]) aluop = c_ALU_SRA;
                        3'b000: if (funct7[5] && r_state == S_REG) aluop = c_ALU_SUB;
                        default: ;
                    endcase
                    w_next = S_FETCH1;
                end
                S_LUI: begin
                    regfilemux_sel = 4'd2;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    w_next         = S_FETCH1;
                end
                S_AUIPC: begin
                    alumux1_sel  = 1'b1;
                    alumux2_sel  = 3'd1;
                    aluop        = c_ALU_ADD;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    w_next       = S_FETCH1;
                end
                S_BR: begin
                    alumux1_sel = 1'b1;
                    alumux2_sel = 3'd2;
                    aluop       = c_ALU_ADD;
                    load_pc     = 1'b1;
                    pcmux_sel   = br_en ? 2'd1 : 2'd0;
                    w_next      = S_FETCH1;
                end
                S_JAL, S_JALR: begin
                    regfilemux_sel = 4'd4;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    aluop          = c_ALU_ADD;
                    alumux1_sel    = (r_state == S_JAL);
                    alumux2_sel    = (r_state == S_JAL) ? 3'd4 : 3'd0;
                    pcmux_sel      = (r_state == S_JAL) ? 2'd1 : 2'd2;
                    w_next         = S_FETCH1;
                end
                S_CALC_ADDR: begin
                    aluop      = c_ALU_ADD;
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    if (opcode == c_OP_LOAD) begin
                        w_next = S_LD1;
                    end else begin
                        alumux2_sel   = 3'd3;
                        load_data_out = 1'b1;
                        w_next        = S_ST1;
                    end
                end
                S_LD1: begin
                    mem_read = 1'b1;
                    load_mdr = 1'b1;
                    if (mem_resp) w_next = S_LD2;
                end
                S_LD2: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    case (funct3)
                        3'b000:  regfilemux_sel = 4'd5;
                        3'b001:  regfilemux_sel = 4'd7;
                        3'b100:  regfilemux_sel = 4'd6;
                        3'b101:  regfilemux_sel = 4'd8;
                        default: regfilemux_sel = 4'd3;
                    endcase
                    w_next = S_FETCH1;
                end
                S_ST1: begin
                    mem_write = 1'b1;
                    case (funct3)
                        3'b000:  mem_byte_enable = 4'b0001 << addr_lo;
                        3'b001:  mem_byte_enable = 4'b0011 << addr_lo;
                        default: mem_byte_enable = 4'b1111;
                    endcase
                    if (mem_resp) w_next = S_ST2;
                end
                S_ST2: begin
                    load_pc = 1'b1;
                    w_next  = S_FETCH1;
                end
                default: w_next = S_FETCH1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_control
// Brief    : Self-checking bench for control: vector table plus sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_control;

    typedef struct packed {
        logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
        logic [1:0] pcmux;
        logic       am1;
        logic [2:0] am2;
        logic       cmpm, marm;
        logic [3:0] rfm;
        logic [2:0] aluop, cmpop;
        logic       mrd, mwr;
        logic [3:0] mbe;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       br;
        outs_t      exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic br_en, mem_resp;
    logic [1:0] addr_lo;
    outs_t act;

    int checks = 0;
    int passed = 0;
    outs_t exp_q[$];
    string nm_q[$];
    vec_t vecs[17];

    always #5 clk = ~clk;

    control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mem_resp(mem_resp), .addr_lo(addr_lo),
        .load_pc(act.load_pc), .load_ir(act.load_ir), .load_regfile(act.load_regfile),
        .load_mar(act.load_mar), .load_mdr(act.load_mdr), .load_data_out(act.load_data_out),
        .pcmux_sel(act.pcmux), .alumux1_sel(act.am1), .alumux2_sel(act.am2),
        .cmpmux_sel(act.cmpm), .marmux_sel(act.marm), .regfilemux_sel(act.rfm),
        .aluop(act.aluop), .cmpop(act.cmpop), .mem_read(act.mrd), .mem_write(act.mwr),
        .mem_byte_enable(act.mbe)
    );

    function automatic outs_t dflt(input logic [2:0] f3);
        outs_t o = '0;
        o.aluop = f3;
        o.cmpop = f3;
        o.mbe   = 4'hF;
        return o;
    endfunction

    function automatic outs_t ex(input logic lpc, input logic lrf, input logic [1:0] pcm,
                                 input logic am1, input logic [2:0] am2, input logic cmpm,
                                 input logic [3:0] rfm, input logic [2:0] aop, input logic [2:0] cop);
        outs_t o = dflt(cop);
        o.load_pc = lpc; o.load_regfile = lrf; o.pcmux = pcm; o.am1 = am1;
        o.am2 = am2; o.cmpm = cmpm; o.rfm = rfm; o.aluop = aop;
        return o;
    endfunction

    // Expected value is queued when the cycle's stimulus is applied, checked mid-cycle.
    task automatic step(input outs_t e, input string nm);
        outs_t x;
        string n;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        x = exp_q.pop_front();
        n = nm_q.pop_front();
        checks++;
        if (act !== x) $display("FAIL %s: got %h expected %h", n, act, x);
        else passed++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
    endtask

    task automatic fetch(input int waits);
        outs_t e;
        e = dflt(funct3); e.load_mar = 1'b1;
        step(e, "fetch1");
        e = dflt(funct3); e.mrd = 1'b1; e.load_mdr = 1'b1;
        mem_resp = 1'b0;
        repeat (waits) step(e, "fetch2_wait");
        mem_resp = 1'b1;
        step(e, "fetch2_resp");
        e = dflt(funct3); e.load_ir = 1'b1;
        step(e, "fetch3");
        step(dflt(funct3), "decode");
        mem_resp = 1'b0;
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [3:0] rfm, input int waits);
        outs_t e;
        set_ir(7'h03, f3, 7'h00);
        fetch(0);
        e = dflt(f3); e.aluop = 3'd0; e.marm = 1'b1; e.load_mar = 1'b1;
        step(e, "calc_ld");
        e = dflt(f3); e.mrd = 1'b1; e.load_mdr = 1'b1;
        repeat (waits) step(e, "ld1_wait");
        mem_resp = 1'b1;
        step(e, "ld1_resp");
        mem_resp = 1'b0;
        e = dflt(f3); e.load_regfile = 1'b1; e.load_pc = 1'b1; e.rfm = rfm;
        step(e, "ld2");
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [1:0] lo, input logic [3:0] mbe, input int waits);
        outs_t e;
        set_ir(7'h23, f3, 7'h00);
        addr_lo = lo;
        fetch(0);
        e = dflt(f3); e.aluop = 3'd0; e.am2 = 3'd3; e.marm = 1'b1; e.load_mar = 1'b1;
        e.load_data_out = 1'b1;
        step(e, "calc_st");
        e = dflt(f3); e.mwr = 1'b1; e.mbe = mbe;
        repeat (waits) step(e, "st1_wait");
        mem_resp = 1'b1;
        step(e, "st1_resp");
        mem_resp = 1'b0;
        e = dflt(f3); e.load_pc = 1'b1;
        step(e, "st2");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t e;
        //          op     f3    f7     br         lpc lrf pcm am1 am2 cmpm rfm aop cop
        vecs[0]  = '{7'h13, 3'd0, 7'h00, 1'b0, ex(1, 1, 0, 0, 0, 0, 0, 0, 0)};        // addi
        vecs[1]  = '{7'h13, 3'd2, 7'h00, 1'b0, ex(1, 1, 0, 0, 0, 1, 1, 2, 3'b100)};   // slti
        vecs[2]  = '{7'h13, 3'd3, 7'h00, 1'b0, ex(1, 1, 0, 0, 0, 1, 1, 3, 3'b110)};   // sltiu
        vecs[3]  = '{7'h13, 3'd5, 7'h20, 1'b0, ex(1, 1, 0, 0, 0, 0, 0, 2, 5)};        // srai
        vecs[4]  = '{7'h13, 3'd5, 7'h00, 1'b0, ex(1, 1, 0, 0, 0, 0, 0, 5, 5)};        // srli
        vecs[5]  = '{7'h33, 3'd0, 7'h00, 1'b0, ex(1, 1, 0, 0, 5, 0, 0, 0, 0)};        // add
        vecs[6]  = '{7'h33, 3'd0, 7'h20, 1'b0, ex(1, 1, 0, 0, 5, 0, 0, 3, 0)};        // sub
        vecs[7]  = '{7'h33, 3'd5, 7'h20, 1'b0, ex(1, 1, 0, 0, 5, 0, 0, 2, 5)};        // sra
        vecs[8]  = '{7'h33, 3'd2, 7'h00, 1'b0, ex(1, 1, 0, 0, 5, 0, 1, 2, 3'b100)};   // slt
        vecs[9]  = '{7'h33, 3'd4, 7'h00, 1'b0, ex(1, 1, 0, 0, 5, 0, 0, 4, 4)};        // xor
        vecs[10] = '{7'h37, 3'd1, 7'h00, 1'b0, ex(1, 1, 0, 0, 0, 0, 2, 1, 1)};        // lui
        vecs[11] = '{7'h17, 3'd2, 7'h00, 1'b0, ex(1, 1, 0, 1, 1, 0, 0, 0, 2)};        // auipc
        vecs[12] = '{7'h63, 3'd0, 7'h00, 1'b1, ex(1, 0, 1, 1, 2, 0, 0, 0, 0)};        // beq taken
        vecs[13] = '{7'h63, 3'd0, 7'h00, 1'b0, ex(1, 0, 0, 1, 2, 0, 0, 0, 0)};        // beq not taken
        vecs[14] = '{7'h63, 3'd4, 7'h00, 1'b1, ex(1, 0, 1, 1, 2, 0, 0, 0, 4)};        // blt taken
        vecs[15] = '{7'h6F, 3'd3, 7'h00, 1'b0, ex(1, 1, 1, 1, 4, 0, 4, 0, 3)};        // jal
        vecs[16] = '{7'h67, 3'd0, 7'h00, 1'b0, ex(1, 1, 2, 0, 0, 0, 4, 0, 0)};        // jalr

        rst = 1'b0; br_en = 1'b0; mem_resp = 1'b0; addr_lo = 2'd0;
        set_ir(7'h00, 3'd0, 7'h00);
        @(posedge clk);
        #1;
        step(dflt(3'd0), "reset_a");
        step(dflt(3'd0), "reset_b");
        rst = 1'b1;

        // First fetch stretches FETCH2 by three wait cycles.
        for (int i = 0; i < 17; i++) begin
            set_ir(vecs[i].op, vecs[i].f3, vecs[i].f7);
            br_en = 1'b0;
            fetch((i == 0) ? 3 : 0);
            br_en = vecs[i].br;
            step(vecs[i].exp, $sformatf("exec_vec%0d", i));
            br_en = 1'b0;
        end

        do_load(3'd2, 4'd3, 2);
        do_load(3'd0, 4'd5, 0);
        do_load(3'd1, 4'd7, 0);
        do_load(3'd4, 4'd6, 0);
        do_load(3'd5, 4'd8, 1);
        do_store(3'd0, 2'd2, 4'b0100, 2);
        do_store(3'd1, 2'd2, 4'b1100, 1);
        do_store(3'd2, 2'd1, 4'b1111, 0);
        do_store(3'd0, 2'd3, 4'b1000, 0);

        // Unknown opcode: decode falls straight back to fetch.
        set_ir(7'h7F, 3'd0, 7'h00);
        fetch(0);

        // Reset while a load is waiting on memory.
        set_ir(7'h03, 3'd2, 7'h00);
        fetch(0);
        e = dflt(3'd2); e.aluop = 3'd0; e.marm = 1'b1; e.load_mar = 1'b1;
        step(e, "calc_ld_rst");
        e = dflt(3'd2); e.mrd = 1'b1; e.load_mdr = 1'b1;
        step(e, "ld1_before_rst");
        rst = 1'b0;
        step(dflt(3'd2), "rst_in_ld1_a");
        step(dflt(3'd2), "rst_in_ld1_b");
        rst = 1'b1;
        set_ir(7'h13, 3'd0, 7'h00);
        fetch(1);
        step(ex(1, 1, 0, 0, 0, 0, 0, 0, 0), "addi_after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have: opcode  in  7, funct3  in  3, funct7  in  7  decoded instruction fields from IR.
REQ-004 SHALL have: br_en  in  1  comparator result; mem_resp  in  1  memory done; addr_lo  in  2  MAR[1:0].
REQ-005 SHALL have: load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register load strobes.
REQ-006 SHALL have: pcmux_sel  out  2 (0 pc_plus4, 1 alu_out, 2 alu_mod2); alumux1_sel  out  1 (0 rs1_out, 1 pc_out).
REQ-007 SHALL have: alumux2_sel  out  3 (0 i_imm, 1 u_imm, 2 b_imm, 3 s_imm, 4 j_imm, 5 rs2_out); cmpmux_sel  out  1 (0 rs2_out, 1 i_imm); marmux_sel  out  1 (0 pc_out, 1 alu_out).
REQ-008 SHALL have: regfilemux_sel  out  4 (0 alu_out, 1 br_en, 2 u_imm, 3 lw, 4 pc_plus4, 5 lb, 6 lbu, 7 lh, 8 lhu).
REQ-009 SHALL have: aluop  out  3 (add 0, sll 1, sra 2, sub 3, xor 4, srl 5, or 6, and 7); cmpop  out  3 (branch funct3 encoding).
REQ-010 SHALL have: mem_read  out  1, mem_write  out  1, mem_byte_enable  out  4.

Function
REQ-011 SHALL be a Moore FSM; every output a function of state plus registered-by-IR fields only; no output depends on mem_resp combinationally except state advance.
REQ-012 SHALL default each cycle: all loads 0, mem_read/mem_write 0, all selects 0, aluop = funct3-mapped, cmpop = funct3, mem_byte_enable = 4'b1111.
REQ-013 SHALL states: FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2.
REQ-014 FETCH1: marmux_sel=0, load_mar=1; next FETCH2.
REQ-015 FETCH2: mem_read=1, load_mdr=1; stay while mem_resp=0; next FETCH3 when mem_resp=1.
REQ-016 FETCH3: load_ir=1; next DECODE. DECODE: no strobes; next by opcode: 0x13 IMM, 0x33 REG, 0x37 LUI, 0x17 AUIPC, 0x63 BR, 0x6F JAL, 0x67 JALR, 0x03/0x23 CALC_ADDR; any other opcode -> FETCH1 with no architectural update.
REQ-017 IMM: load_regfile=1, load_pc=1; funct3 010 -> cmpop=blt, cmpmux_sel=1, regfilemux_sel=1; 011 -> cmpop=bltu, same; 101 with funct7[5]=1 -> aluop=sra; else aluop=funct3, alumux2_sel=0, regfilemux_sel=0.
REQ-018 REG: as IMM but alumux2_sel=5, cmpmux_sel=0; funct3 000 with funct7[5]=1 -> aluop=sub; 101 with funct7[5]=1 -> sra.
REQ-019 LUI: regfilemux_sel=2, load_regfile=1, load_pc=1. AUIPC: alumux1_sel=1, alumux2_sel=1, aluop=add, load_regfile=1, load_pc=1.
REQ-020 BR: cmpop=funct3, cmpmux_sel=0, alumux1_sel=1, alumux2_sel=2, aluop=add, load_pc=1, pcmux_sel = br_en ? 1 : 0.
REQ-021 JAL: regfilemux_sel=4, load_regfile=1, alumux1_sel=1, alumux2_sel=4, aluop=add, pcmux_sel=1, load_pc=1. JALR: same but alumux1_sel=0, alumux2_sel=0, pcmux_sel=2.
REQ-022 IMM, REG, LUI, AUIPC, BR, JAL, JALR SHALL each last one cycle and return to FETCH1.
REQ-023 CALC_ADDR: aluop=add, alumux2_sel=0 (load) or 3 (store), marmux_sel=1, load_mar=1; store also load_data_out=1; next LD1 or ST1.
REQ-024 LD1: mem_read=1, load_mdr=1; hold until mem_resp=1; next LD2. LD2: load_regfile=1, load_pc=1, regfilemux_sel per funct3 (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu); next FETCH1.
REQ-025 ST1: mem_write=1, mem_byte_enable: sw 1111; sh 0011<<addr_lo; sb 0001<<addr_lo; hold until mem_resp=1; next ST2. ST2: load_pc=1; next FETCH1.
REQ-026 mem_read and mem_write SHALL never assert simultaneously; each SHALL remain constant-high throughout a wait.
REQ-027 mem_resp asserted outside FETCH2/LD1/ST1 SHALL be ignored.

Reset
REQ-028 rst=0 at a rising edge SHALL force state FETCH1 next cycle from any state, including mid-wait in FETCH2/LD1/ST1, dropping the access.
REQ-029 While in reset all outputs SHALL equal REQ-012 defaults (mem_read=0, mem_write=0, all loads 0).

Verification
REQ-030 Reset: rst=0 two cycles during LD1 -> mem_read=0 next cycle, FETCH1 outputs (load_mar=1) first cycle after rst=1.
REQ-031 Fetch wait: mem_resp low 3 cycles in FETCH2 -> mem_read=1 for 4 cycles, load_ir=1 exactly one cycle after mem_resp.
REQ-032 ADDI (0x13, f3=000): IMM cycle shows aluop=0, alumux2_sel=0, regfilemux_sel=0, load_regfile=1, load_pc=1.
REQ-033 BEQ br_en=1 -> pcmux_sel=1, load_pc=1; br_en=0 -> pcmux_sel=0, load_regfile=0.
REQ-034 SB addr_lo=2 -> mem_byte_enable=0100, mem_write=1 until mem_resp; SH addr_lo=2 -> 1100.
REQ-035 Opcode 0x7F -> DECODE then FETCH1, no load_regfile/load_pc asserted.
